// File: rtl/pe_start_fifo_pkg.sv
// Shared definitions for the PE start-token FIFO: pointer/occupancy widths,
// the empty pointer encoding and the per-cycle handshake operation.
package pe_start_fifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // All ones; truncated to the pointer width it reads as -1 (empty).
  localparam logic [31:0] PTR_EMPTY = '1;

  function automatic int ptr_w(input int addr_width);
    return addr_width + 1;
  endfunction

  // Occupancy spans 0..DEPTH with DEPTH <= 2**addr_width.
  function automatic int occ_w(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/pe_start_fifo_srl_storage.sv
// Address-indexed shift-register token store: a write shifts din into slot 0,
// the read port is a combinational mux on addr.
module pe_start_fifo_srl_storage #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the shift array has no reset so it maps onto SRL primitives;
  // validity is tracked entirely by the controller's pointer and flags.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  // The empty pointer's low bits can index past DEPTH when DEPTH < 2**ADDR_WIDTH.
  assign dout = (int'(addr) < DEPTH) ? mem[addr] : '0;

endmodule

// File: rtl/pe_start_token_fifo.sv
// Start-token FIFO controller around the SRL store: pointer, registered flags
// and handshake. Define START_FIFO_OCC_EN to add occupancy/capacity outputs.
module pe_start_token_fifo
  import pe_start_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
`ifdef START_FIFO_OCC_EN
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic [ADDR_WIDTH:0]   if_fifo_cap,
`endif
  output logic                  if_empty_n
);

  localparam int PW = ptr_w(ADDR_WIDTH);
  localparam logic [PW-1:0] PTR_INIT = PTR_EMPTY[PW-1:0];
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 2);
  localparam logic [PW-1:0] PTR_MAX  = PW'(DEPTH - 1);

  logic [PW-1:0] ptr_q;
  logic          push;
  logic          pop;
  fifo_op_e      op;

  assign push = if_write & if_write_ce & if_full_n;
  assign pop  = if_read & if_read_ce & if_empty_n;
  assign op   = fifo_op_e'({push, pop});

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= PTR_INIT;
      if_empty_n <= 1'b0;
      if_full_n  <= 1'b1;
    end else begin
      case (op)
        OP_PUSH: begin
          ptr_q      <= ptr_q + 1'b1;
          if_empty_n <= 1'b1;
          if (ptr_q == PTR_LAST) if_full_n <= 1'b0;
        end
        OP_POP: begin
          ptr_q     <= ptr_q - 1'b1;
          if_full_n <= 1'b1;
          if (ptr_q == '0) if_empty_n <= 1'b0;
        end
        default: ;  // idle, or push+pop: SRL shift alone re-aligns slot ptr
      endcase
    end
  end

  pe_start_fifo_srl_storage #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_storage (
    .clk (clk),
    .we  (push),
    .addr(ptr_q[ADDR_WIDTH-1:0]),
    .din (if_din),
    .dout(if_dout)
  );

`ifdef START_FIFO_OCC_EN
  localparam int OW = occ_w(ADDR_WIDTH);

  logic [OW-1:0] occ_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      case (op)
        OP_PUSH: occ_q <= occ_q + 1'b1;
        OP_POP:  occ_q <= occ_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign if_num_data_valid = occ_q;
  assign if_fifo_cap       = OW'(DEPTH);
`endif

`ifndef SYNTHESIS
  ptr_in_range: assert property (@(posedge clk) disable iff (reset)
    (ptr_q == PTR_INIT) || (ptr_q <= PTR_MAX));
`endif

endmodule

// File: tb/tb_pe_start_token_fifo.sv
// Directed bench for pe_start_token_fifo: a DEPTH=4 instance for the main
// sequence and a DEPTH=2 instance for the minimum-depth corner.
module tb_pe_start_token_fifo;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  // DEPTH=4 instance
  logic       a_write_ce, a_write, a_read_ce, a_read;
  logic [7:0] a_din, a_dout;
  logic       a_full_n, a_empty_n;
`ifdef START_FIFO_OCC_EN
  logic [2:0] a_occ, a_cap;
`endif

  // DEPTH=2 instance
  logic       b_write_ce, b_write, b_read_ce, b_read;
  logic [7:0] b_din, b_dout;
  logic       b_full_n, b_empty_n;
`ifdef START_FIFO_OCC_EN
  logic [1:0] b_occ, b_cap;
`endif

  pe_start_token_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4)) dut_a (
    .clk              (clk),
    .reset            (reset),
    .if_write_ce      (a_write_ce),
    .if_write         (a_write),
    .if_din           (a_din),
    .if_full_n        (a_full_n),
    .if_read_ce       (a_read_ce),
    .if_read          (a_read),
    .if_dout          (a_dout),
`ifdef START_FIFO_OCC_EN
    .if_num_data_valid(a_occ),
    .if_fifo_cap      (a_cap),
`endif
    .if_empty_n       (a_empty_n)
  );

  pe_start_token_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(1), .DEPTH(2)) dut_b (
    .clk              (clk),
    .reset            (reset),
    .if_write_ce      (b_write_ce),
    .if_write         (b_write),
    .if_din           (b_din),
    .if_full_n        (b_full_n),
    .if_read_ce       (b_read_ce),
    .if_read          (b_read),
    .if_dout          (b_dout),
`ifdef START_FIFO_OCC_EN
    .if_num_data_valid(b_occ),
    .if_fifo_cap      (b_cap),
`endif
    .if_empty_n       (b_empty_n)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic occ_a(input string tag, input int expected);
`ifdef START_FIFO_OCC_EN
    check(tag, 32'(a_occ), 32'(expected));
`endif
  endtask

  initial begin
    reset      = 1'b1;
    a_write_ce = 1'b1; a_write = 1'b0; a_read_ce = 1'b1; a_read = 1'b0; a_din = '0;
    b_write_ce = 1'b1; b_write = 1'b0; b_read_ce = 1'b1; b_read = 1'b0; b_din = '0;
    #1;
    check("reset_empty_n", 32'(a_empty_n), 32'd0);
    check("reset_full_n", 32'(a_full_n), 32'd1);
    step();
    step();
    reset = 1'b0;
    step(); step(); step();
    check("idle_empty_n", 32'(a_empty_n), 32'd0);
    check("idle_full_n", 32'(a_full_n), 32'd1);
    occ_a("idle_occ", 0);
`ifdef START_FIFO_OCC_EN
    check("fifo_cap", 32'(a_cap), 32'd4);
`endif

    // Fill to capacity.
    a_write = 1'b1;
    a_din = 8'h11; step();
    check("push1_empty_n", 32'(a_empty_n), 32'd1);
    a_din = 8'h22; step();
    a_din = 8'h33; step();
    check("push3_full_n", 32'(a_full_n), 32'd1);
    a_din = 8'h44; step();
    check("push4_full_n", 32'(a_full_n), 32'd0);
    occ_a("full_occ", 4);
    a_din = 8'h55; step();
    check("push5_blocked_full_n", 32'(a_full_n), 32'd0);
    occ_a("push5_blocked_occ", 4);
    a_write = 1'b0;

    // Drain in order; 0x55 must not appear.
    a_read = 1'b1;
    check("pop1_dout", 32'(a_dout), 32'h11); step();
    check("pop1_full_n", 32'(a_full_n), 32'd1);
    check("pop2_dout", 32'(a_dout), 32'h22); step();
    check("pop3_dout", 32'(a_dout), 32'h33); step();
    check("pop4_empty_n_before", 32'(a_empty_n), 32'd1);
    check("pop4_dout", 32'(a_dout), 32'h44); step();
    check("pop4_empty_n", 32'(a_empty_n), 32'd0);
    occ_a("drained_occ", 0);
    a_read = 1'b0;

    // Simultaneous push and pop at occupancy 2.
    a_write = 1'b1;
    a_din = 8'hA1; step();
    a_din = 8'hA2; step();
    a_read = 1'b1;
    check("both1_dout", 32'(a_dout), 32'hA1); a_din = 8'hB1; step();
    check("both1_flags", 32'({a_empty_n, a_full_n}), 32'b11);
    occ_a("both1_occ", 2);
    check("both2_dout", 32'(a_dout), 32'hA2); a_din = 8'hB2; step();
    check("both2_flags", 32'({a_empty_n, a_full_n}), 32'b11);
    check("both3_dout", 32'(a_dout), 32'hB1); a_din = 8'hB3; step();
    check("both3_flags", 32'({a_empty_n, a_full_n}), 32'b11);
    occ_a("both3_occ", 2);
    a_write = 1'b0;
    check("tail1_dout", 32'(a_dout), 32'hB2); step();
    check("tail2_dout", 32'(a_dout), 32'hB3); step();
    check("tail_empty_n", 32'(a_empty_n), 32'd0);
    a_read = 1'b0;

    // Blocked pop on empty, then push with write-side enable low.
    a_read = 1'b1; step();
    a_read = 1'b0;
    check("pop_empty_flags", 32'({a_empty_n, a_full_n}), 32'b01);
    occ_a("pop_empty_occ", 0);
    a_write_ce = 1'b0; a_write = 1'b1; a_din = 8'hEE; step();
    a_write_ce = 1'b1; a_write = 1'b0;
    check("push_ce0_flags", 32'({a_empty_n, a_full_n}), 32'b01);
    occ_a("push_ce0_occ", 0);
    // Pointer must still be at empty: one push then one pop round-trips.
    a_write = 1'b1; a_din = 8'h3C; step();
    a_write = 1'b0;
    check("after_block_dout", 32'(a_dout), 32'h3C);
    a_read = 1'b1; step();
    a_read = 1'b0;
    check("after_block_empty_n", 32'(a_empty_n), 32'd0);

    // Asynchronous reset between edges discards stored tokens.
    a_write = 1'b1;
    a_din = 8'h5A; step();
    a_din = 8'h6B; step();
    a_write = 1'b0;
    check("pre_reset_empty_n", 32'(a_empty_n), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_flags", 32'({a_empty_n, a_full_n}), 32'b01);
    occ_a("async_reset_occ", 0);
    #1 reset = 1'b0;
    step();
    a_write = 1'b1; a_din = 8'h77; step();
    a_write = 1'b0;
    check("post_reset_empty_n", 32'(a_empty_n), 32'd1);
    check("post_reset_dout", 32'(a_dout), 32'h77);
    occ_a("post_reset_occ", 1);
    a_read = 1'b1; step();
    a_read = 1'b0;
    check("post_reset_drained", 32'(a_empty_n), 32'd0);

    // Minimum depth instance.
    b_write = 1'b1;
    b_din = 8'h01; step();
    check("d2_push1_full_n", 32'(b_full_n), 32'd1);
    b_din = 8'h00; step();
    b_write = 1'b0;
    check("d2_full_n", 32'(b_full_n), 32'd0);
`ifdef START_FIFO_OCC_EN
    check("d2_occ", 32'(b_occ), 32'd2);
`endif
    check("d2_pop1_dout", 32'(b_dout), 32'h01);
    b_read = 1'b1; step();
    b_read = 1'b0;
    check("d2_pop_full_n", 32'(b_full_n), 32'd1);
    check("d2_second_dout", 32'(b_dout), 32'h00);
    check("d2_empty_n", 32'(b_empty_n), 32'd1);
    b_read = 1'b1; step();
    b_read = 1'b0;
    check("d2_drained", 32'(b_empty_n), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
